calc_iter_alu: RTL and testbench

//  Parametrised multi-cycle arithmetic engine behind the calculator menu controller. It accepts one

---
 rtl/calc_pkg.sv | 18 +
 rtl/calc_div_core.sv | 55 +++++
 rtl/calc_iter_alu.sv | 246 ++++++++++++++++++++++++
 tb/tb_calc_iter_alu.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - opcodes and one-hot states shared by the calculator engine and menu controller
package calc_pkg;

  localparam logic [2:0] OP_ADD     = 3'd0;
  localparam logic [2:0] OP_SUB     = 3'd1;
  localparam logic [2:0] OP_DIV     = 3'd2;
  localparam logic [2:0] OP_MULT    = 3'd3;
  localparam logic [2:0] OP_GCD     = 3'd4;
  localparam logic [2:0] OP_ISPRIME = 3'd5;
  localparam logic [2:0] OP_SQRT    = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_RUN  = 3'b010,
    S_DONE = 3'b100
  } state_t;

endpackage

// File: rtl/calc_div_core.sv
// rtl/calc_div_core.sv - restoring shift-subtract divider, WIDTH iterations per start
// done, quotient and remainder are combinational during the final iteration.
module calc_div_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] q, r, d;
  logic [CW-1:0]    cnt;
  logic             busy;
  logic [WIDTH:0]   shifted, diff;
  logic             fits;

  assign shifted   = {r, q[WIDTH-1]};
  assign diff      = shifted - {1'b0, d};
  assign fits      = shifted >= {1'b0, d};
  assign remainder = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quotient  = {q[WIDTH-2:0], fits};
  assign done      = busy && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= '0;
      r    <= '0;
      d    <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (clear) begin
      busy <= 1'b0;
    end else if (start) begin
      q    <= dividend;
      r    <= '0;
      d    <= divisor;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      q   <= quotient;
      r   <= remainder;
      cnt <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/calc_iter_alu.sv
// rtl/calc_iter_alu.sv - multi-cycle add/sub/mult/div/gcd/isprime/sqrt engine with Start/Done handshake
// Optional CALC_CYCLE_COUNT_EN adds the Cycles port reporting RUN cycles of the last completed op.
module calc_iter_alu #(
  parameter int WIDTH = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Abort,
  input  logic [2:0]         Op,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] Result,
  output logic [WIDTH-1:0]   Rem,
  output logic               Flag,
  output logic               Err
`ifdef CALC_CYCLE_COUNT_EN
  ,
  output logic [15:0]        Cycles
`endif
);

  import calc_pkg::*;

  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state, next_state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] x, y, d, x_n, y_n, d_n;
  logic [RW-1:0]    acc, acc_n;
  logic [CW-1:0]    cnt;
  logic             accept, finish;
  logic [RW-1:0]    fin_result;
  logic [WIDTH-1:0] fin_rem;
  logic             fin_flag, fin_err;

  logic             div_start, div_done;
  logic [WIDTH-1:0] div_dividend, div_divisor, div_quo, div_rem;

  logic [WIDTH:0]   sub_diff, mul_sum;
  logic [RW-1:0]    mul_next, sq_shift, sq_trial, sq_rem_n, d_sq;
  logic [WIDTH-1:0] sq_root_n, d_inc;
  logic             sq_fits, d_past, last_mul, last_sqrt;

  assign sub_diff  = {1'b0, x} - {1'b0, y};
  // Multiplier uses the product register: upper half accumulates, lower half shifts out B.
  assign mul_sum   = {1'b0, acc[RW-1:WIDTH]} + (acc[0] ? {1'b0, x} : '0);
  assign mul_next  = {mul_sum, acc[WIDTH-1:1]};
  assign sq_shift  = {acc[RW-3:0], x[WIDTH-1:WIDTH-2]};
  assign sq_trial  = {{(WIDTH-2){1'b0}}, y, 2'b01};
  assign sq_fits   = sq_shift >= sq_trial;
  assign sq_rem_n  = sq_fits ? sq_shift - sq_trial : sq_shift;
  assign sq_root_n = {y[WIDTH-2:0], sq_fits};
  assign d_inc     = d + WIDTH'(1);
  assign d_sq      = RW'(d_inc) * RW'(d_inc);
  assign d_past    = d_sq > RW'(x);
  assign last_mul  = cnt == CW'(WIDTH - 1);
  assign last_sqrt = cnt == CW'(WIDTH / 2 - 1);

  assign accept = (state == S_IDLE) && Start && !Abort;
  assign Busy   = (state == S_RUN) || (state == S_DONE);
  assign Done   = (state == S_DONE);

  calc_div_core #(.WIDTH(WIDTH)) u_div (
    .clk       (Clk),
    .rst       (Reset),
    .clear     (Abort && (state != S_IDLE)),
    .start     (div_start),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state   = state;
    finish       = 1'b0;
    fin_result   = '0;
    fin_rem      = '0;
    fin_flag     = 1'b0;
    fin_err      = 1'b0;
    x_n          = x;
    y_n          = y;
    d_n          = d;
    acc_n        = acc;
    div_start    = 1'b0;
    div_dividend = x;
    div_divisor  = d_inc;
    case (state)
      S_IDLE: begin
        if (accept) begin
          next_state   = S_RUN;
          x_n          = A;
          y_n          = (Op == OP_SQRT) ? '0 : B;
          d_n          = WIDTH'(2);
          acc_n        = (Op == OP_MULT) ? RW'(B) : '0;
          div_dividend = A;
          div_divisor  = (Op == OP_DIV) ? B : WIDTH'(2);
          div_start    = ((Op == OP_DIV) && (B != '0)) ||
                         ((Op == OP_ISPRIME) && (A >= WIDTH'(4)));
        end
      end
      S_RUN: begin
        if (Abort) begin
          next_state = S_IDLE;
        end else begin
          case (op_q)
            OP_ADD: begin
              finish     = 1'b1;
              fin_result = RW'(x) + RW'(y);
            end
            OP_SUB: begin
              finish     = 1'b1;
              fin_result = {{(WIDTH-1){sub_diff[WIDTH]}}, sub_diff};
              fin_flag   = sub_diff[WIDTH];
            end
            OP_DIV: begin
              if (y == '0) begin
                finish     = 1'b1;
                fin_err    = 1'b1;
                fin_result = '1;
                fin_rem    = x;
              end else if (div_done) begin
                finish     = 1'b1;
                fin_result = RW'(div_quo);
                fin_rem    = div_rem;
              end
            end
            OP_MULT: begin
              acc_n = mul_next;
              if (last_mul) begin
                finish     = 1'b1;
                fin_result = mul_next;
              end
            end
            OP_GCD: begin
              if ((x == '0) || (y == '0) || (x == y)) begin
                finish     = 1'b1;
                fin_result = RW'(x | y);
              end else if (x > y) begin
                x_n = x - y;
              end else begin
                y_n = y - x;
              end
            end
            OP_ISPRIME: begin
              // Values below 4 have no trial divisor with d*d <= A.
              if (x < WIDTH'(4)) begin
                finish     = 1'b1;
                fin_flag   = x >= WIDTH'(2);
                fin_result = RW'(fin_flag);
              end else if (div_done) begin
                if (div_rem == '0) begin
                  finish = 1'b1;
                end else if (d_past) begin
                  finish     = 1'b1;
                  fin_flag   = 1'b1;
                  fin_result = RW'(1);
                end else begin
                  div_start = 1'b1;
                  d_n       = d_inc;
                end
              end
            end
            OP_SQRT: begin
              x_n   = x << 2;
              y_n   = sq_root_n;
              acc_n = sq_rem_n;
              if (last_sqrt) begin
                finish     = 1'b1;
                fin_result = RW'(sq_root_n);
                fin_rem    = sq_rem_n[WIDTH-1:0];
              end
            end
            default: begin
              finish  = 1'b1;
              fin_err = 1'b1;
            end
          endcase
          if (finish) next_state = S_DONE;
        end
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      x      <= '0;
      y      <= '0;
      d      <= '0;
      acc    <= '0;
      cnt    <= '0;
      op_q   <= '0;
      Result <= '0;
      Rem    <= '0;
      Flag   <= 1'b0;
      Err    <= 1'b0;
    end else begin
      x   <= x_n;
      y   <= y_n;
      d   <= d_n;
      acc <= acc_n;
      if (accept) begin
        op_q <= Op;
        cnt  <= '0;
      end else if (state == S_RUN) begin
        cnt <= cnt + CW'(1);
      end
      if (finish) begin
        Result <= fin_result;
        Rem    <= fin_rem;
        Flag   <= fin_flag;
        Err    <= fin_err;
      end
    end
  end

`ifdef CALC_CYCLE_COUNT_EN
  logic [15:0] run_cycles, run_cycles_inc;

  assign run_cycles_inc = (run_cycles == 16'hFFFF) ? run_cycles : run_cycles + 16'd1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      run_cycles <= '0;
      Cycles     <= '0;
    end else begin
      if (accept)              run_cycles <= '0;
      else if (state == S_RUN) run_cycles <= run_cycles_inc;
      if (finish) Cycles <= run_cycles_inc;
    end
  end
`endif

endmodule

// File: tb/tb_calc_iter_alu.sv
// tb/tb_calc_iter_alu.sv - directed vector table plus abort/reset/busy sequences for calc_iter_alu
module tb_calc_iter_alu;

  import calc_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset, Start, Abort;
  logic [2:0]  Op;
  logic [7:0]  A, B;
  logic        Busy, Done, Flag, Err;
  logic [15:0] Result;
  logic [7:0]  Rem;
`ifdef CALC_CYCLE_COUNT_EN
  logic [15:0] Cycles;
`endif

  int total = 0;
  int bad   = 0;

  calc_iter_alu #(.WIDTH(8)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Start  (Start),
    .Abort  (Abort),
    .Op     (Op),
    .A      (A),
    .B      (B),
    .Busy   (Busy),
    .Done   (Done),
    .Result (Result),
    .Rem    (Rem),
    .Flag   (Flag),
    .Err    (Err)
`ifdef CALC_CYCLE_COUNT_EN
    ,
    .Cycles (Cycles)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic [7:0]  rem;
    logic        flag;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Cycle 0 is the cycle Start is driven; lat is the first cycle Done is seen (0 = never).
  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input int inj_cyc, input int inj_kind, input int max_cyc,
                        output int lat, output logic busy_after);
    lat        = 0;
    busy_after = 1'b0;
    @(negedge Clk);
    Op = op; A = a; B = b; Start = 1'b1;
    @(posedge Clk);
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge Clk);
      if (c == inj_cyc + 1) busy_after = Busy;
      if (Done && lat == 0) lat = c;
      Start = 1'b0;
      Abort = 1'b0;
      if (c == inj_cyc) begin
        if (inj_kind == 1) begin
          Start = 1'b1; Op = OP_ADD; A = 8'd1; B = 8'd1;
        end else if (inj_kind == 2) begin
          Abort = 1'b1;
        end
      end
      if (lat != 0) break;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   lat;
    logic ba;

    vecs[0]  = '{OP_ADD,     8'd200, 8'd100, 16'h012C, 8'd0,  1'b0, 1'b0, 2};
    vecs[1]  = '{OP_ADD,     8'd255, 8'd255, 16'h01FE, 8'd0,  1'b0, 1'b0, 2};
    vecs[2]  = '{OP_SUB,     8'd5,   8'd9,   16'hFFFC, 8'd0,  1'b1, 1'b0, 2};
    vecs[3]  = '{OP_SUB,     8'd9,   8'd5,   16'h0004, 8'd0,  1'b0, 1'b0, 2};
    vecs[4]  = '{OP_MULT,    8'd255, 8'd255, 16'hFE01, 8'd0,  1'b0, 1'b0, 9};
    vecs[5]  = '{OP_MULT,    8'd13,  8'd11,  16'h008F, 8'd0,  1'b0, 1'b0, 9};
    vecs[6]  = '{OP_DIV,     8'd200, 8'd7,   16'd28,   8'd4,  1'b0, 1'b0, 9};
    vecs[7]  = '{OP_DIV,     8'd13,  8'd0,   16'hFFFF, 8'd13, 1'b0, 1'b1, 2};
    vecs[8]  = '{OP_DIV,     8'd255, 8'd16,  16'd15,   8'd15, 1'b0, 1'b0, 9};
    vecs[9]  = '{OP_GCD,     8'd48,  8'd18,  16'd6,    8'd0,  1'b0, 1'b0, 6};
    vecs[10] = '{OP_GCD,     8'd0,   8'd0,   16'd0,    8'd0,  1'b0, 1'b0, 2};
    vecs[11] = '{OP_GCD,     8'd0,   8'd9,   16'd9,    8'd0,  1'b0, 1'b0, 2};
    vecs[12] = '{OP_GCD,     8'd9,   8'd0,   16'd9,    8'd0,  1'b0, 1'b0, 2};
    vecs[13] = '{OP_ISPRIME, 8'd251, 8'd0,   16'd1,    8'd0,  1'b1, 1'b0, 0};
    vecs[14] = '{OP_ISPRIME, 8'd91,  8'd0,   16'd0,    8'd0,  1'b0, 1'b0, 0};
    vecs[15] = '{OP_ISPRIME, 8'd1,   8'd0,   16'd0,    8'd0,  1'b0, 1'b0, 2};
    vecs[16] = '{OP_ISPRIME, 8'd2,   8'd0,   16'd1,    8'd0,  1'b1, 1'b0, 0};
    vecs[17] = '{OP_ISPRIME, 8'd4,   8'd0,   16'd0,    8'd0,  1'b0, 1'b0, 0};
    vecs[18] = '{OP_SQRT,    8'd200, 8'd0,   16'd14,   8'd4,  1'b0, 1'b0, 5};
    vecs[19] = '{OP_SQRT,    8'd255, 8'd0,   16'd15,   8'd30, 1'b0, 1'b0, 5};
    vecs[20] = '{OP_SQRT,    8'd0,   8'd0,   16'd0,    8'd0,  1'b0, 1'b0, 5};
    vecs[21] = '{3'd7,       8'd3,   8'd4,   16'd0,    8'd0,  1'b0, 1'b1, 2};

    Reset = 1'b1; Start = 1'b0; Abort = 1'b0; Op = '0; A = '0; B = '0;
    @(negedge Clk);
    @(negedge Clk);
    check("reset busy",   32'(Busy),   32'd0);
    check("reset done",   32'(Done),   32'd0);
    check("reset result", 32'(Result), 32'd0);
    check("reset rem",    32'(Rem),    32'd0);
    check("reset flag",   32'(Flag),   32'd0);
    check("reset err",    32'(Err),    32'd0);
`ifdef CALC_CYCLE_COUNT_EN
    check("reset cycles", 32'(Cycles), 32'd0);
`endif
    Reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, -1, 0, 300, lat, ba);
      check($sformatf("v%0d result", i), 32'(Result), 32'(vecs[i].res));
      check($sformatf("v%0d rem", i),    32'(Rem),    32'(vecs[i].rem));
      check($sformatf("v%0d flag", i),   32'(Flag),   32'(vecs[i].flag));
      check($sformatf("v%0d err", i),    32'(Err),    32'(vecs[i].err));
      if (vecs[i].lat != 0) check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      else                  check($sformatf("v%0d done seen", i), 32'(lat != 0), 32'd1);
      @(negedge Clk);
      check($sformatf("v%0d done pulse", i), 32'(Done), 32'd0);
      check($sformatf("v%0d busy after", i), 32'(Busy), 32'd0);
    end

    // Start during a running DIV must be ignored.
    run_op(OP_DIV, 8'd200, 8'd7, 3, 1, 40, lat, ba);
    check("busy start latency", 32'(lat),    32'd9);
    check("busy start result",  32'(Result), 32'd28);
    check("busy start rem",     32'(Rem),    32'd4);
    @(negedge Clk);
    check("busy start no rerun", 32'(Busy), 32'd0);

    // Abort mid-DIV: back to idle, no Done, previous outputs held.
    run_op(OP_ADD, 8'd1, 8'd2, -1, 0, 20, lat, ba);
    check("pre abort result", 32'(Result), 32'd3);
    @(negedge Clk);
    run_op(OP_DIV, 8'd200, 8'd7, 4, 2, 20, lat, ba);
    check("abort no done",   32'(lat),    32'd0);
    check("abort busy low",  32'(ba),     32'd0);
    check("abort result",    32'(Result), 32'd3);
    check("abort rem",       32'(Rem),    32'd0);

    // Start together with Abort in IDLE is refused.
    @(negedge Clk);
    Op = OP_ADD; A = 8'd9; B = 8'd9; Start = 1'b1; Abort = 1'b1;
    @(negedge Clk);
    Start = 1'b0; Abort = 1'b0;
    check("start+abort busy", 32'(Busy), 32'd0);
    @(negedge Clk);
    check("start+abort busy later", 32'(Busy), 32'd0);
    check("start+abort result", 32'(Result), 32'd3);

`ifdef CALC_CYCLE_COUNT_EN
    run_op(OP_MULT, 8'd3, 8'd4, -1, 0, 20, lat, ba);
    check("cycles mult result", 32'(Result), 32'd12);
    check("cycles mult",        32'(Cycles), 32'd8);
    run_op(OP_DIV, 8'd200, 8'd7, 4, 2, 20, lat, ba);
    check("cycles after abort", 32'(Cycles), 32'd8);
    run_op(OP_ADD, 8'd1, 8'd2, -1, 0, 20, lat, ba);
    check("cycles add",         32'(Cycles), 32'd1);
`endif

    // Asynchronous reset in the middle of a MULT.
    @(negedge Clk);
    Op = OP_MULT; A = 8'd255; B = 8'd255; Start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    check("mid mult busy", 32'(Busy), 32'd1);
    Reset = 1'b1;
    #1;
    check("mid reset busy",   32'(Busy),   32'd0);
    check("mid reset done",   32'(Done),   32'd0);
    check("mid reset result", 32'(Result), 32'd0);
    check("mid reset rem",    32'(Rem),    32'd0);
    check("mid reset flag",   32'(Flag),   32'd0);
    check("mid reset err",    32'(Err),    32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    check("post reset no done", 32'(Done), 32'd0);
    run_op(OP_ADD, 8'd1, 8'd1, -1, 0, 20, lat, ba);
    check("post reset add",     32'(Result), 32'd2);
    check("post reset latency", 32'(lat),    32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
